csr_controller: RTL and testbench
=================================

CSR_CONTROLLER -- requirements
Module: csr_controller

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: csr_req  input  1  instruction CSR access request, held until csr_ready.
REQ-004 SHALL have: csr_op  input  csr_op_e (2)  CSR_RW, CSR_RS or CSR_RC.
REQ-005 SHALL have: csr_addr_in  input  12  target CSR address.
REQ-006 SHALL have: csr_src  input  32  rs1 value or zero-extended uimm.
REQ-007 SHALL have: csr_wr_en  input  1  0 suppresses the write (RS/RC with x0/uimm=0).
REQ-008 SHALL have: csr_ready  output  1  one-cycle pulse; csr_rdata valid.
REQ-009 SHALL have: csr_rdata  output  32  old CSR value.
REQ-010 SHALL have: trap_req, mret_req  input  1 each  held until trap_done / mret_done.
REQ-011 SHALL have: trap_pc, trap_cause, trap_tval  input  32 each.
REQ-012 SHALL have: trap_done, mret_done  output  1 each  one-cycle pulses.
REQ-013 SHALL have: trap_vector, mret_pc  output  32 each  valid while the matching done pulse is high.
REQ-014 SHALL have: reg_we  output  reg_we_e; reg_addr  output  12; reg_wdata  output  32; reg_rdata  input  32 (asynchronous read); these drive the CSR register file.
REQ-015 SHALL have: busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CSR_RD, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_TVAL, TRAP_VEC, MRET_RD.
REQ-017 In IDLE, priority SHALL be trap_req > mret_req > csr_req; the winner's inputs are latched on that edge. Requests are ignored while busy.
REQ-018 IDLE->CSR_RD: the latched address is driven and reg_rdata captured as the old value.
REQ-019 CSR_RD->CSR_WR: new value is src (RW), old|src (RS) or old&~src (RC); reg_we=REG_WE only if csr_wr_en. csr_ready=1 and csr_rdata=old; the next state is IDLE.
REQ-020 Instruction access latency SHALL be: request sampled at edge N, csr_ready high during the cycle after edge N+1.
REQ-021 Trap sequence SHALL be TRAP_EPC (write 0x341=trap_pc), TRAP_CAUSE (0x342=trap_cause), TRAP_TVAL (0x343=trap_tval), TRAP_VEC (read 0x305), then IDLE.
REQ-022 In TRAP_VEC, trap_done=1 and trap_vector={reg_rdata[31:2],2'b00}.
REQ-023 In MRET_RD, the controller SHALL read 0x341 and assert mret_done=1 with mret_pc={reg_rdata[31:2],2'b00}, then go to IDLE.
REQ-024 reg_we SHALL be REG_WE only in the write cycles named above; otherwise it is the not-write value.
REQ-025 Simultaneous trap_req and csr_req in IDLE SHALL serve the trap; the CSR access starts in the first IDLE cycle after trap_done.

Reset
REQ-026 On rst: state=IDLE; csr_ready, trap_done and mret_done=0; csr_rdata, trap_vector and mret_pc=0; reg_we=no-write.
REQ-027 Reset mid-sequence SHALL abort without any further register-file write; writes already performed remain.

Configuration
REQ-028 Macro RV32I_CSR_MCYCLE_EN: when defined, a 64-bit mcycle counter is cleared on rst and incremented every cycle.
REQ-029 With RV32I_CSR_MCYCLE_EN defined, reads of 0xB00/0xB80 SHALL return counter[31:0]/[63:32] in place of reg_rdata.
REQ-030 With RV32I_CSR_MCYCLE_EN defined, a write to 0xB00/0xB80 SHALL load that half and suppress the increment for that cycle.
REQ-031 When RV32I_CSR_MCYCLE_EN is undefined, there is no counter and 0xB00/0xB80 behave as plain registers.

Structure
REQ-032 Package rv32i SHALL hold csr_op_e, the CSR address constants (MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343, MCYCLE 0xB00, MCYCLEH 0xB80) and the FSM state enum.
REQ-033 The read-modify-write computation SHALL be a combinational sub-module csr_alu (op, old, src -> new).

Verification
REQ-034 Bench SHALL cover: preload 0x300=0x0000_00F0; CSR_RS src=0x0F -> csr_rdata=0xF0, 0x300 becomes 0xFF, ready 2 cycles after accept.
REQ-035 Bench SHALL cover: 0x300=0xFF; CSR_RC src=0x0F with csr_wr_en=0 -> csr_rdata=0xFF, no write, 0x300 stays 0xFF.
REQ-036 Bench SHALL cover: mtvec=0x8000_0101; trap pc=0x100, cause=2, tval=0xDEAD -> mepc/mcause/mtval written in order, trap_vector=0x8000_0100, trap_done on cycle 4.
REQ-037 Bench SHALL cover: trap_req and csr_req asserted together -> trap completes first, then the CSR access completes.
REQ-038 Bench SHALL cover: mepc=0x203; mret_req -> mret_pc=0x200 and mret_done one cycle after accept.
REQ-039 Bench SHALL cover: rst asserted in TRAP_CAUSE -> mepc written, mcause unchanged, FSM returns to IDLE; with RV32I_CSR_MCYCLE_EN, a read of 0xB00 10 cycles after rst returns a value ≥10.

Source files
------------

// File: rtl/csr_controller_pkg.sv
// Shared types and constants for the machine-mode CSR controller.
// Package rv32i holds the CSR op encoding, the register-file write
// strobe type, the CSR address map and the controller FSM states.
package rv32i;

    typedef enum logic [1:0] {
        CSR_RW = 2'b01,
        CSR_RS = 2'b10,
        CSR_RC = 2'b11
    } csr_op_e;

    typedef enum logic {
        REG_NO_WE = 1'b0,
        REG_WE    = 1'b1
    } reg_we_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CSR_RD     = 3'd1,
        CSR_WR     = 3'd2,
        TRAP_EPC   = 3'd3,
        TRAP_CAUSE = 3'd4,
        TRAP_TVAL  = 3'd5,
        TRAP_VEC   = 3'd6,
        MRET_RD    = 3'd7
    } csr_state_e;

    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;
    localparam logic [11:0] MTVAL   = 12'h343;
    localparam logic [11:0] MCYCLE  = 12'hB00;
    localparam logic [11:0] MCYCLEH = 12'hB80;

    // Clear the two low bits so a target address is word aligned.
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/csr_controller_alu.sv
// Read-modify-write datapath for CSR instructions:
// RW replaces, RS sets the src bits, RC clears the src bits.
module csr_alu
    import rv32i::*;
(
    input  csr_op_e     op,
    input  logic [31:0] old_value,
    input  logic [31:0] src,
    output logic [31:0] new_value
);

    // Select the new CSR value from the op.
    always_comb begin
        new_value = src;
        case (op)
            CSR_RW:  new_value = src;
            CSR_RS:  new_value = old_value | src;
            CSR_RC:  new_value = old_value & ~src;
            default: new_value = src;
        endcase
    end

endmodule

// File: rtl/csr_controller.sv
// Machine-mode CSR controller: serialises instruction CSR accesses,
// trap entry (mepc/mcause/mtval writes then mtvec read) and mret
// (mepc read) onto a single-port CSR register file.
// Optional feature macro: RV32I_CSR_MCYCLE_EN adds a free-running
// 64-bit mcycle counter that shadows CSRs 0xB00/0xB80.
module csr_controller
    import rv32i::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req,
    input  csr_op_e     csr_op,
    input  logic [11:0] csr_addr_in,
    input  logic [31:0] csr_src,
    input  logic        csr_wr_en,
    output logic        csr_ready,
    output logic [31:0] csr_rdata,
    input  logic        trap_req,
    input  logic        mret_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    output logic        trap_done,
    output logic        mret_done,
    output logic [31:0] trap_vector,
    output logic [31:0] mret_pc,
    output reg_we_e     reg_we,
    output logic [11:0] reg_addr,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    output logic        busy
);

    csr_state_e  state;
    csr_state_e  next_state;

    csr_op_e     op_q;
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic        wr_en_q;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    logic [31:0] tval_q;
    logic [31:0] old_q;
    logic [31:0] rd_value;
    logic [31:0] new_value;

    csr_alu u_alu (
        .op        (op_q),
        .old_value (old_q),
        .src       (src_q),
        .new_value (new_value)
    );

`ifdef RV32I_CSR_MCYCLE_EN
    logic [63:0] mcycle;

    // Count every cycle; a CSR write to either half loads it instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle <= 64'd0;
        end else if (reg_we == REG_WE && reg_addr == MCYCLE) begin
            mcycle <= {mcycle[63:32], reg_wdata};
        end else if (reg_we == REG_WE && reg_addr == MCYCLEH) begin
            mcycle <= {reg_wdata, mcycle[31:0]};
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

    // Counter halves take the place of the register-file value on reads.
    always_comb begin
        rd_value = reg_rdata;
        if (addr_q == MCYCLE) begin
            rd_value = mcycle[31:0];
        end else if (addr_q == MCYCLEH) begin
            rd_value = mcycle[63:32];
        end
    end
`else
    assign rd_value = reg_rdata;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the winning request's operands on accept; capture the old CSR value in CSR_RD.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (trap_req) begin
                pc_q    <= trap_pc;
                cause_q <= trap_cause;
                tval_q  <= trap_tval;
            end else if (!mret_req && csr_req) begin
                op_q    <= csr_op;
                addr_q  <= csr_addr_in;
                src_q   <= csr_src;
                wr_en_q <= csr_wr_en;
            end
        end
        if (state == CSR_RD) begin
            old_q <= rd_value;
        end
    end

    // Next-state decode and register-file / handshake outputs.
    always_comb begin
        next_state  = state;
        reg_we      = REG_NO_WE;
        reg_addr    = addr_q;
        reg_wdata   = new_value;
        csr_ready   = 1'b0;
        csr_rdata   = 32'd0;
        trap_done   = 1'b0;
        trap_vector = 32'd0;
        mret_done   = 1'b0;
        mret_pc     = 32'd0;

        case (state)
            IDLE: begin
                if (trap_req) begin
                    next_state = TRAP_EPC;
                end else if (mret_req) begin
                    next_state = MRET_RD;
                end else if (csr_req) begin
                    next_state = CSR_RD;
                end
            end
            CSR_RD: begin
                next_state = CSR_WR;
            end
            CSR_WR: begin
                if (wr_en_q) begin
                    reg_we = REG_WE;
                end
                csr_ready  = 1'b1;
                csr_rdata  = old_q;
                next_state = IDLE;
            end
            TRAP_EPC: begin
                reg_we     = REG_WE;
                reg_addr   = MEPC;
                reg_wdata  = pc_q;
                next_state = TRAP_CAUSE;
            end
            TRAP_CAUSE: begin
                reg_we     = REG_WE;
                reg_addr   = MCAUSE;
                reg_wdata  = cause_q;
                next_state = TRAP_TVAL;
            end
            TRAP_TVAL: begin
                reg_we     = REG_WE;
                reg_addr   = MTVAL;
                reg_wdata  = tval_q;
                next_state = TRAP_VEC;
            end
            TRAP_VEC: begin
                reg_addr    = MTVEC;
                trap_done   = 1'b1;
                trap_vector = align4(reg_rdata);
                next_state  = IDLE;
            end
            MRET_RD: begin
                reg_addr   = MEPC;
                mret_done  = 1'b1;
                mret_pc    = align4(reg_rdata);
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // A reset cycle aborts the sequence: no write reaches the register
        // file on the reset edge and no handshake is reported.
        if (rst) begin
            reg_we      = REG_NO_WE;
            csr_ready   = 1'b0;
            csr_rdata   = 32'd0;
            trap_done   = 1'b0;
            trap_vector = 32'd0;
            mret_done   = 1'b0;
            mret_pc     = 32'd0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_csr_controller.sv
// Bench for csr_controller: directed scenarios plus randomized CSR
// accesses, traps and mrets checked against an address-indexed model
// of the CSR contents. Covers the optional RV32I_CSR_MCYCLE_EN build.
module tb_csr_controller;
    import rv32i::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req;
    csr_op_e     csr_op;
    logic [11:0] csr_addr_in;
    logic [31:0] csr_src;
    logic        csr_wr_en;
    logic        csr_ready;
    logic [31:0] csr_rdata;
    logic        trap_req;
    logic        mret_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        trap_done;
    logic        mret_done;
    logic [31:0] trap_vector;
    logic [31:0] mret_pc;
    reg_we_e     reg_we;
    logic [11:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        busy;

    always #5 clk = ~clk;

    csr_controller dut (
        .clk         (clk),
        .rst         (rst),
        .csr_req     (csr_req),
        .csr_op      (csr_op),
        .csr_addr_in (csr_addr_in),
        .csr_src     (csr_src),
        .csr_wr_en   (csr_wr_en),
        .csr_ready   (csr_ready),
        .csr_rdata   (csr_rdata),
        .trap_req    (trap_req),
        .mret_req    (mret_req),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .trap_tval   (trap_tval),
        .trap_done   (trap_done),
        .mret_done   (mret_done),
        .trap_vector (trap_vector),
        .mret_pc     (mret_pc),
        .reg_we      (reg_we),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .busy        (busy)
    );

    // CSR register file: async read, write on rising edge, plus a bench preload port.
    logic [31:0] rf [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'd0;
    logic [31:0] pl_data = 32'd0;
    int          wcount = 0;
    logic [11:0] wlog [$];

    always @(posedge clk) begin
        if (reg_we == REG_WE) begin
            rf[reg_addr] <= reg_wdata;
            wcount <= wcount + 1;
            wlog.push_back(reg_addr);
        end else if (pl_en) begin
            rf[pl_addr] <= pl_data;
        end
    end
    assign reg_rdata = rf[reg_addr];

    // Reference model: expected CSR contents by address.
    logic [31:0] model [logic [11:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_new(input csr_op_e op, input logic [31:0] old,
                                               input logic [31:0] src);
        if (op == CSR_RW) return src;
        if (op == CSR_RS) return old | src;
        return old & ~src;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        model[a] = d;
    endtask

    // One instruction access; lat = cycles after accept until csr_ready (0 = timeout).
    task automatic do_csr(input csr_op_e op, input logic [11:0] a, input logic [31:0] s,
                          input logic we, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        csr_req = 1'b1; csr_op = op; csr_addr_in = a; csr_src = s; csr_wr_en = we;
        lat = 0; rdata = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (csr_ready) begin
                lat = k; rdata = csr_rdata;
                break;
            end
        end
        csr_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic csr_step(input string tag, input csr_op_e op, input logic [11:0] a,
                            input logic [31:0] s, input logic we);
        logic [31:0] rd;
        logic [31:0] old;
        int          lat;
        int          w0;
        old = model[a];
        w0 = wcount;
        do_csr(op, a, s, we, rd, lat);
        if (we) model[a] = expect_new(op, old, s);
        chk({tag, "_rdata"}, rd, old);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_value"}, rf[a], model[a]);
        chk({tag, "_nwrites"}, wcount - w0, we ? 1 : 0);
    endtask

    task automatic trap_step(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] tval);
        int          lat;
        int          idx;
        logic [31:0] vec;
        idx = wlog.size();
        @(negedge clk);
        trap_req = 1'b1; trap_pc = pc; trap_cause = cause; trap_tval = tval;
        lat = 0; vec = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (trap_done) begin
                lat = k; vec = trap_vector;
                break;
            end
        end
        trap_req = 1'b0;
        @(posedge clk); #1;
        model[MEPC] = pc; model[MCAUSE] = cause; model[MTVAL] = tval;
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_vector"}, vec, {model[MTVEC][31:2], 2'b00});
        chk({tag, "_mepc"}, rf[MEPC], pc);
        chk({tag, "_mcause"}, rf[MCAUSE], cause);
        chk({tag, "_mtval"}, rf[MTVAL], tval);
        chk({tag, "_order"},
            {(wlog.size() > idx)     ? wlog[idx]     : 12'hFFF,
             (wlog.size() > idx + 1) ? wlog[idx + 1] : 12'hFFF,
             (wlog.size() > idx + 2) ? wlog[idx + 2] : 12'hFFF},
            {MEPC, MCAUSE, MTVAL});
    endtask

    task automatic mret_step(input string tag);
        int          lat;
        logic [31:0] pc;
        @(negedge clk);
        mret_req = 1'b1;
        lat = 0; pc = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (mret_done) begin
                lat = k; pc = mret_pc;
                break;
            end
        end
        mret_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_pc"}, pc, {model[MEPC][31:2], 2'b00});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs [6];
        logic [31:0] rd;
        int          lat;
        int          tk;
        int          ck;
        int          w0;

        addrs = '{12'h300, 12'h304, MTVEC, MEPC, MCAUSE, MTVAL};
        rst = 1'b1; csr_req = 1'b0; csr_op = CSR_RW; csr_addr_in = 12'd0; csr_src = 32'd0;
        csr_wr_en = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
        trap_pc = 32'd0; trap_cause = 32'd0; trap_tval = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", csr_ready, 0);
        chk("rst_rdata", csr_rdata, 0);
        chk("rst_trap_done", trap_done, 0);
        chk("rst_mret_done", mret_done, 0);
        chk("rst_vector", trap_vector, 0);
        chk("rst_mret_pc", mret_pc, 0);
        chk("rst_we", reg_we, REG_NO_WE);
        @(negedge clk);
        rst = 1'b0;

        foreach (addrs[i]) preload(addrs[i], $urandom());

        // Set bits: 0xF0 | 0x0F
        preload(12'h300, 32'h0000_00F0);
        csr_step("rs_set", CSR_RS, 12'h300, 32'h0F, 1'b1);
        chk("rs_set_result", rf[12'h300], 32'hFF);

        // Clear with write suppressed
        csr_step("rc_nowr", CSR_RC, 12'h300, 32'h0F, 1'b0);
        chk("rc_nowr_result", rf[12'h300], 32'hFF);

        // Trap entry
        preload(MTVEC, 32'h8000_0101);
        trap_step("trap", 32'h100, 32'h2, 32'hDEAD);

        // Trap and CSR request together: trap first, CSR access right after
        preload(12'h304, 32'h1234_5678);
        @(negedge clk);
        trap_req = 1'b1; trap_pc = 32'h400; trap_cause = 32'h7; trap_tval = 32'h99;
        csr_req = 1'b1; csr_op = CSR_RW; csr_addr_in = 12'h304; csr_src = 32'hCAFE_0000;
        csr_wr_en = 1'b1;
        tk = 0; ck = 0; rd = 32'd0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (trap_done) begin
                tk = k; trap_req = 1'b0;
            end
            if (csr_ready) begin
                ck = k; rd = csr_rdata; csr_req = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        model[MEPC] = 32'h400; model[MCAUSE] = 32'h7; model[MTVAL] = 32'h99;
        model[12'h304] = 32'hCAFE_0000;
        chk("both_trap_lat", tk, 4);
        chk("both_csr_lat", ck, 7);
        chk("both_rdata", rd, 32'h1234_5678);
        chk("both_value", rf[12'h304], 32'hCAFE_0000);
        chk("both_mepc", rf[MEPC], 32'h400);

        // mret
        preload(MEPC, 32'h203);
        mret_step("mret");

        // Reset during TRAP_CAUSE
        preload(MEPC, 32'h11);
        preload(MCAUSE, 32'h22);
        @(negedge clk);
        trap_req = 1'b1; trap_pc = 32'h444; trap_cause = 32'h5; trap_tval = 32'h6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        w0 = wcount;
        rst = 1'b1;
        trap_req = 1'b0;
        #0;
        chk("abort_we", reg_we, REG_NO_WE);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model[MEPC] = 32'h444;
        chk("abort_busy", busy, 0);
        chk("abort_mepc", rf[MEPC], 32'h444);
        chk("abort_mcause", rf[MCAUSE], 32'h22);
        chk("abort_nwrites", wcount - w0, 0);

`ifdef RV32I_CSR_MCYCLE_EN
        repeat (7) @(posedge clk);
        do_csr(CSR_RS, MCYCLE, 32'd0, 1'b0, rd, lat);
        chk("mcycle_ge10", (rd >= 32'd10), 1);
        chk("mcycle_lat", lat, 2);
`else
        preload(MCYCLE, 32'h0000_1234);
        csr_step("mcycle_plain", CSR_RW, MCYCLE, 32'h55, 1'b1);
`endif

        // Randomized mix of accesses, traps and mrets
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                trap_step("rnd_trap", $urandom(), $urandom(), $urandom());
            end else if (sel == 1) begin
                mret_step("rnd_mret");
            end else begin
                csr_op_e op;
                case ($urandom_range(0, 2))
                    0:       op = CSR_RW;
                    1:       op = CSR_RS;
                    default: op = CSR_RC;
                endcase
                csr_step("rnd_csr", op, addrs[$urandom_range(0, 5)], $urandom(),
                         ($urandom_range(0, 3) != 0));
            end
        end

        foreach (addrs[i]) chk("final_value", rf[addrs[i]], model[addrs[i]]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
